// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: funct3 encodings, FSM states, byte-enable width and misalignment rule for the load/store unit
package riscv_lsu_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} lsu_state_t;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1] && off != 2'b00);
  endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte enables, store lane replication and load lane extraction/extension (i_funct3, i_off, i_wdata, i_rdata -> o_be, o_wdata, o_rdata)
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [BE_W-1:0] o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);
  logic            w_byte;
  logic            w_half;
  logic [1:0]      w_off;
  logic [XLEN-1:0] w_sh;
  always_comb begin
    w_byte  = i_funct3[1:0] == 2'b00;
    w_half  = i_funct3[1:0] == 2'b01;
    w_off   = w_byte ? i_off : w_half ? {i_off[1], 1'b0} : 2'b00;
    w_sh    = i_rdata >> {w_off, 3'b000};
    o_be    = w_byte ? (BE_W'(1) << w_off) : w_half ? (BE_W'(3) << w_off) : '1;
    o_wdata = w_byte ? {(XLEN/8){i_wdata[7:0]}} : w_half ? {(XLEN/16){i_wdata[15:0]}} : i_wdata;
    o_rdata = w_byte ? {{(XLEN-8){~i_funct3[2] & w_sh[7]}}, w_sh[7:0]}
            : w_half ? {{(XLEN-16){~i_funct3[2] & w_sh[15]}}, w_sh[15:0]} : i_rdata;
  end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I load/store unit (req_*/is_store/funct3/addr/wdata in, mem_* bus, rsp_* result) with IDLE/BUS/RESP/ERR FSM, bus timeout, and misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  lsu_state_t      r_state;
  lsu_state_t      w_next;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic [CW-1:0]   r_cnt;
  logic            w_trap;
  logic            w_accept;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_ext;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = misaligned(funct3, addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif
  assign w_accept = req_valid && r_state == S_IDLE;
  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3(r_funct3),
    .i_off   (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (r_rdata),
    .o_be    (w_be),
    .o_wdata (mem_wdata),
    .o_rdata (w_ext)
  );
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (req_valid ? (w_trap ? S_ERR : S_BUS) : S_IDLE)
           : r_state == S_BUS  ? (mem_ack ? S_RESP : r_cnt == T_LAST ? S_ERR : S_BUS)
           : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == S_BUS ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_we     <= is_store;
        r_funct3 <= funct3;
        r_addr   <= addr;
        r_wdata  <= wdata;
      end
      if (r_state == S_BUS && mem_ack) r_rdata <= mem_rdata;
    end
  end
  assign req_ready = rst_n && r_state == S_IDLE;
  assign mem_req   = rst_n && r_state == S_BUS;
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = {r_addr[XLEN-1:2], 2'b00};
  assign mem_be    = mem_req ? w_be : '0;
  assign rsp_valid = rst_n && (r_state == S_RESP || r_state == S_ERR);
  assign rsp_err   = rst_n && r_state == S_ERR;
  assign rsp_rdata = (rst_n && r_state == S_RESP && !r_we) ? w_ext : '0;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and randomized load/store transactions checked against a behavioural lane model
module tb_riscv_lsu;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  int n_chk = 0;
  int n_err = 0;
  riscv_lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int dly, output logic [31:0] got_rd, output logic got_err);
    int sz, off, nbus;
    logic [31:0] mask, exp_rd, exp_wd, exp_be;
    logic trap;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = (int'(a[1:0]) / sz) * sz;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(a[1:0]) % sz) != 0;
`endif
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    exp_rd = (rd >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && exp_rd[8*sz-1]) exp_rd = exp_rd | ~mask;
    if (st) exp_rd = 32'd0;
    exp_wd = (sz == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 : (sz == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
    exp_be = ((32'd1 << sz) - 32'd1) << off;
    @(negedge clk);
    check("ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    if (trap) begin
      check("trap_req", {31'd0, mem_req}, 32'd0);
      check("trap_vld", {31'd0, rsp_valid}, 32'd1);
      check("trap_err", {31'd0, rsp_err}, 32'd1);
      check("trap_rd", rsp_rdata, 32'd0);
      got_rd = rsp_rdata; got_err = rsp_err;
    end else begin
      nbus = (dly < TO) ? dly + 1 : TO;
      for (int j = 0; j < nbus; j++) begin
        check("bus_req", {31'd0, mem_req}, 32'd1);
        check("bus_we", {31'd0, mem_we}, {31'd0, st});
        check("bus_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("bus_be", {28'd0, mem_be}, exp_be);
        if (st) check("bus_wd", mem_wdata, exp_wd);
        check("bus_novld", {31'd0, rsp_valid}, 32'd0);
        mem_ack = (j == dly);
        mem_rdata = (j == dly) ? rd : $urandom;
        req_valid = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
        funct3 = 3'($urandom); is_store = 1'($urandom);
        @(negedge clk);
      end
      req_valid = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      check("rsp_req", {31'd0, mem_req}, 32'd0);
      check("rsp_vld", {31'd0, rsp_valid}, 32'd1);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, dly >= TO});
      check("rsp_rd", rsp_rdata, (dly >= TO) ? 32'd0 : exp_rd);
      got_rd = rsp_rdata; got_err = rsp_err;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("vld_once", {31'd0, rsp_valid}, 32'd0);
  endtask
  logic [31:0] g_rd;
  logic        g_err;
  logic [2:0]  st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_vld", {31'd0, rsp_valid}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, g_rd, g_err);
    check("lw_word", g_rd, 32'hDEAD_BEEF);
    txn(1'b0, 3'b000, 32'h103, 32'd0, 32'h8000_0000, 1, g_rd, g_err);
    check("lb_sext", g_rd, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h103, 32'd0, 32'h8000_0000, 2, g_rd, g_err);
    check("lbu_zext", g_rd, 32'h0000_0080);
    txn(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h1111_2222, 1, g_rd, g_err);
    check("sh_rd0", g_rd, 32'd0);
    txn(1'b0, 3'b010, 32'h200, 32'd0, 32'h5555_AAAA, 99, g_rd, g_err);
    check("timeout_err", {31'd0, g_err}, 32'd1);
    txn(1'b0, 3'b101, 32'h202, 32'd0, 32'h8765_4321, TO - 1, g_rd, g_err);
    check("late_ack_ok", {31'd0, g_err}, 32'd0);
    txn(1'b0, 3'b010, 32'h101, 32'd0, 32'h1234_5678, 0, g_rd, g_err);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_err", {31'd0, g_err}, 32'd1);
`else
    check("misalign_word", g_rd, 32'h1234_5678);
`endif
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    check("rb_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rb_req_rst", {31'd0, mem_req}, 32'd0);
    check("rb_vld_rst", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rb_vld_ack", {31'd0, rsp_valid}, 32'd0);
    check("rb_ready", {31'd0, req_ready}, 32'd1);
    check("rb_req_ack", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    check("rb_vld_late", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 60; i++) begin
      logic st;
      logic [2:0] f3;
      st = 1'($urandom_range(0, 1));
      f3 = st ? st_f3[$urandom_range(0, 5)] : 3'($urandom);
      txn(st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 5), g_rd, g_err);
      repeat ($urandom_range(0, 2)) begin
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      mem_ack = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
